// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared types and CRC constants for the USB receive parser
package usb_pkg;

    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_SETUP = 4'b1101,
        PID_DATA0 = 4'b0011,
        PID_DATA1 = 4'b1011,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010,
        PID_STALL = 4'b1110
    } pid_t;

    typedef enum logic [1:0] {
        KIND_TOKEN     = 2'b00,
        KIND_DATA      = 2'b01,
        KIND_HANDSHAKE = 2'b10,
        KIND_UNKNOWN   = 2'b11
    } pkt_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PID  = 2'd1,
        ST_BODY = 2'd2,
        ST_DONE = 2'd3
    } parse_state_t;

    localparam logic [4:0]  CRC5_POLY      = 5'b00101;
    localparam logic [4:0]  CRC5_INIT      = 5'b11111;
    localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
    localparam logic [6:0]  TOKEN_LEN      = 7'd16;

    function automatic pkt_kind_t pid_kind(input logic [3:0] p);
        case (p)
            PID_OUT, PID_IN, PID_SETUP: pid_kind = KIND_TOKEN;
            PID_DATA0, PID_DATA1:       pid_kind = KIND_DATA;
            PID_ACK, PID_NAK, PID_STALL: pid_kind = KIND_HANDSHAKE;
            default:                    pid_kind = KIND_UNKNOWN;
        endcase
    endfunction

endpackage

// File: rtl/usb_crc_chk.sv
// rtl/usb_crc_chk.sv - serial CRC LFSR with clear and enable
module usb_crc_chk #(
    parameter int         W    = 5,
    parameter logic [W-1:0] POLY = '0,
    parameter logic [W-1:0] INIT = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         din,
    output logic [W-1:0] crc
);

    logic w_fb;
    assign w_fb = din ^ crc[W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= INIT;
        end else if (clr) begin
            crc <= INIT;
        end else if (en) begin
            crc <= {crc[W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
        end
    end

endmodule

// File: rtl/usb_pkt_parser.sv
// rtl/usb_pkt_parser.sv - serial USB packet parser: PID, token/data/handshake fields and error checks
module usb_pkt_parser
    import usb_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR  = 7'd0,
    parameter int         DATA_BITS = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 recving,
    input  logic                 in_valid,
    input  logic                 inb,
    output logic                 pkt_valid,
    output logic [1:0]           pkt_kind,
    output logic [3:0]           pid,
    output logic [6:0]           addr,
    output logic [3:0]           endp,
    output logic [DATA_BITS-1:0] data,
    output logic                 addr_match,
    output logic                 pid_err,
    output logic                 crc_err,
    output logic                 len_err
);

    localparam int         BODY_W   = DATA_BITS + 16;
    localparam logic [6:0] DATA_LEN = 7'(BODY_W);

    parse_state_t       r_state, w_next;
    logic [7:0]         r_pid_sr;
    logic [2:0]         r_pid_cnt;
    logic [6:0]         r_body_cnt;
    logic [BODY_W-1:0]  r_body;
    logic [4:0]         w_crc5;
    logic [15:0]        w_crc16;
    logic               w_bit, w_start, w_finish, w_crc_clr, w_crc_en;
    logic               w_pid_ok, w_len_bad, w_crc_bad;
    pkt_kind_t          w_kind;
    logic [6:0]         w_exp_len;

    assign w_bit     = recving && in_valid;
    assign w_crc_en  = (r_state == ST_BODY) && w_bit;
    assign pkt_valid = (r_state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // A packet may start in DONE as well as IDLE; the bit on that cycle is the first PID bit
    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_finish  = 1'b0;
        w_crc_clr = 1'b0;
        case (r_state)
            ST_IDLE: if (recving) begin w_next = ST_PID; w_start = 1'b1; end
            ST_PID: begin
                if (!recving) begin
                    w_next = ST_DONE; w_finish = 1'b1;
                end else if (in_valid && r_pid_cnt == 3'd7) begin
                    w_next = ST_BODY; w_crc_clr = 1'b1;
                end
            end
            ST_BODY: if (!recving) begin w_next = ST_DONE; w_finish = 1'b1; end
            ST_DONE: begin
                if (recving) begin w_next = ST_PID; w_start = 1'b1; end
                else         w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_pid_ok  = (r_pid_sr[7:4] == ~r_pid_sr[3:0]);
        w_kind    = w_pid_ok ? pid_kind(r_pid_sr[3:0]) : KIND_UNKNOWN;
        w_exp_len = 7'd0;
        w_crc_bad = 1'b0;
        case (w_kind)
            KIND_TOKEN: begin w_exp_len = TOKEN_LEN; w_crc_bad = (w_crc5 != CRC5_RESIDUAL); end
            KIND_DATA:  begin w_exp_len = DATA_LEN;  w_crc_bad = (w_crc16 != CRC16_RESIDUAL); end
            default:    begin w_exp_len = 7'd0;      w_crc_bad = 1'b0; end
        endcase
        w_len_bad = (r_state == ST_PID) ||
                    ((w_kind != KIND_UNKNOWN) && (r_body_cnt != w_exp_len));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pid_sr   <= '0;
            r_pid_cnt  <= '0;
            r_body_cnt <= '0;
            r_body     <= '0;
            pkt_kind   <= '0;
            pid        <= '0;
            addr       <= '0;
            endp       <= '0;
            data       <= '0;
            addr_match <= 1'b0;
            pid_err    <= 1'b0;
            crc_err    <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            if (w_start) begin
                r_pid_sr   <= in_valid ? {inb, 7'd0} : 8'd0;
                r_pid_cnt  <= in_valid ? 3'd1 : 3'd0;
                r_body_cnt <= '0;
                r_body     <= '0;
                pid_err    <= 1'b0;
                crc_err    <= 1'b0;
                len_err    <= 1'b0;
            end else if (r_state == ST_PID && w_bit) begin
                r_pid_sr  <= {inb, r_pid_sr[7:1]};
                r_pid_cnt <= r_pid_cnt + 3'd1;
            end else if (r_state == ST_BODY && w_bit) begin
                // Excess bits are counted (for len_err) but never overwrite stored fields
                if (r_body_cnt < DATA_LEN) r_body[r_body_cnt] <= inb;
                if (r_body_cnt != 7'd127)  r_body_cnt <= r_body_cnt + 7'd1;
            end
            if (w_finish) begin
                pkt_kind   <= (r_state == ST_PID) ? KIND_UNKNOWN : w_kind;
                pid        <= r_pid_sr[3:0];
                addr       <= r_body[6:0];
                endp       <= r_body[10:7];
                data       <= r_body[DATA_BITS-1:0];
                addr_match <= (r_state == ST_BODY) && (w_kind == KIND_TOKEN) &&
                              (r_body[6:0] == DEV_ADDR);
                pid_err    <= !w_pid_ok || (w_kind == KIND_UNKNOWN);
                len_err    <= w_len_bad;
                crc_err    <= !w_len_bad && w_crc_bad;
            end
        end
    end

    usb_crc_chk #(.W(5), .POLY(CRC5_POLY), .INIT(CRC5_INIT)) u_crc5 (
        .clk (clk),
        .rst (rst),
        .clr (w_crc_clr),
        .en  (w_crc_en),
        .din (inb),
        .crc (w_crc5)
    );

    usb_crc_chk #(.W(16), .POLY(CRC16_POLY), .INIT(CRC16_INIT)) u_crc16 (
        .clk (clk),
        .rst (rst),
        .clr (w_crc_clr),
        .en  (w_crc_en),
        .din (inb),
        .crc (w_crc16)
    );

endmodule
